task1_s_init: RTL and testbench
===============================

// Module: task1_s_init
// PURPOSE
//  ARC4 stage-1 top for the DE1-SoC: after reset, fills an internal 256x8
//  state memory S with the identity permutation S[i]=i (i=0..255), then
//  raises a done flag. Sits at board level; later ARC4 stages (KSA, PRGA)
//  reuse the filled S. A debug readback shows S[SW[7:0]] on HEX1:HEX0.
// PARAMETERS
//  (none; memory depth fixed at 256, width 8)
// PORTS
//  CLOCK_50  in   1   system clock, all logic on rising edge
//  KEY[3]    in   1   reset: synchronous, active-high (1 = reset asserted)
//  KEY[2:0]  in   3   unused, ignored
//  SW        in   10  SW[7:0] readback address; SW[9:8] ignored
//  HEX0      out  7   low nibble of S[SW[7:0]], 7-seg active-low {g..a}
//  HEX1      out  7   high nibble of S[SW[7:0]], 7-seg active-low
//  HEX2..HEX5 out 7 each  always blank (7'h7F)
//  LEDR      out  10  LEDR[0]=done; LEDR[9:1]=0
// BEHAVIOUR
//  - One clock domain; single synchronous active-high reset on KEY[3].
//  - Reset (any cycle KEY[3]=1 at clock edge): state<=FILL, i<=0,
//    done<=0, LEDR<=0, HEX0..HEX5<=7'h7F. Memory contents NOT cleared.
//  - States: FILL -> DONE. No IDLE; fill starts on the first edge with
//    KEY[3]=0.
//  - FILL: each edge writes S[i]<=i[7:0], i<=i+1 (9-bit counter). Edge k
//    (k=0 = first edge after reset release) writes S[k]. On the edge
//    writing S[255], state<=DONE and done<=1; LEDR[0]=1 visible after
//    exactly 256 edges. Counter never wraps into a second pass.
//  - DONE: write port disabled; state held until reset. Reset asserted
//    mid-FILL or in DONE restarts at i=0 on release (S rewritten).
//  - Memory: 256x8, synchronous write, synchronous read (1-cycle latency),
//    one write port (fill) + one read port (SW[7:0]); inferred RAM.
//  - Readback: read address = SW[7:0] registered; HEX1/HEX0 registered
//    from read data => display reflects SW change within 2 edges. While
//    done=0, HEX0/HEX1 = 7'h7F (blank).
//  - 7-seg codes (active-low, bit6=g..bit0=a): 0=40 1=79 2=24 3=30 4=19
//    5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex).
//  - HEX2..HEX5 constant 7'h7F; LEDR[9:1] constant 0.
//  - Simultaneous reset and final write: reset wins (done stays 0).
// TESTING
//  - Reset held 3 edges -> LEDR=0, all HEX=7'h7F, no state change.
//  - Release reset, count edges -> LEDR[0]=0 after 255 edges, =1 after 256.
//  - After done, SW=8'h00 -> HEX1=40,HEX0=40; SW=8'hA5 -> HEX1=08,HEX0=12;
//    SW=8'hFF -> HEX1=0E,HEX0=0E; each within 2 edges.
//  - Sweep SW[7:0]=0..255 after done -> display matches address, all 256.
//  - Assert reset at edge 100 of FILL for 1 edge -> LEDR[0] clears, rises
//    256 edges after release; S still identity.
//  - SW[9:8], KEY[2:0] toggled during FILL -> no effect on timing/contents.

Source files
------------

// File: rtl/task1_s_init_if.sv
// Board-level I/O bundle for the ARC4 stage-1 block.
//   SW        : switches; SW[7:0] select the S[] entry shown on the display
//   HEX0..5   : 7-segment digits, active-low {g..a}
//   LEDR      : LEDs; LEDR[0] = fill done
// master = board/bench side (drives SW), slave = design side.
interface task1_s_init_if;
  logic [9:0] SW;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic [9:0] LEDR;

  modport master (output SW,
                  input  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, LEDR);
  modport slave  (input  SW,
                  output HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, LEDR);
endinterface

// File: rtl/task1_s_init.sv
// ARC4 stage 1: after reset, fill the 256x8 state memory S with the identity
// permutation (S[i] = i), then raise done on LEDR[0].
// A debug readback shows S[SW[7:0]] on HEX1:HEX0 once the fill is done.
//   CLOCK_50 : clock, all logic on rising edge
//   KEY[3]   : synchronous active-high reset; KEY[2:0] ignored
//   io       : SW in, HEX0..HEX5 / LEDR out (see task1_s_init_if)
module task1_s_init (
  input  logic       CLOCK_50,
  input  logic [3:0] KEY,
  task1_s_init_if.slave io
);

  localparam logic [6:0] BLANK = 7'h7F;

  typedef enum logic {FILL, DONE} state_t;

  logic       rst;
  state_t     state;
  logic [8:0] i;
  logic       done;
  logic [6:0] hex0_q, hex1_q;
  logic [7:0] rd_data;
  logic       we;
  logic [7:0] mem [256];

  assign rst = KEY[3];

  // Ignored board inputs.
  logic unused_inputs;
  assign unused_inputs = ^{KEY[2:0], io.SW[9:8]};

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
  endfunction

  // Write is blocked during reset so a reset coinciding with the final
  // write never half-completes a pass.
  assign we = (state == FILL) && !rst;

  // Inferred RAM: one write port (fill), one synchronous read port (SW).
  // Contents survive reset on purpose; the next fill rewrites them.
  always_ff @(posedge CLOCK_50) begin
    if (we) mem[i[7:0]] <= i[7:0];
    rd_data <= mem[io.SW[7:0]];
  end

  // Control FSM with registered display outputs.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state  <= FILL;
      i      <= '0;
      done   <= 1'b0;
      hex0_q <= BLANK;
      hex1_q <= BLANK;
    end else begin
      case (state)
        FILL: begin
          i <= i + 9'd1;
          // Last write of the pass: stop here so the counter never wraps.
          if (i == 9'd255) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: ;
        default: state <= FILL;
      endcase
      // Display stays blank until S is fully populated.
      if (done) begin
        hex0_q <= seg7(rd_data[3:0]);
        hex1_q <= seg7(rd_data[7:4]);
      end else begin
        hex0_q <= BLANK;
        hex1_q <= BLANK;
      end
    end
  end

  assign io.HEX0 = hex0_q;
  assign io.HEX1 = hex1_q;
  assign io.HEX2 = BLANK;
  assign io.HEX3 = BLANK;
  assign io.HEX4 = BLANK;
  assign io.HEX5 = BLANK;
  assign io.LEDR = {9'b0, done};

endmodule

// File: tb/tb_task1_s_init.sv
module tb_task1_s_init;

  logic       clk;
  logic [3:0] key;
  logic       probe;
  int         checks;
  int         errors;

  task1_s_init_if bus ();

  task1_s_init dut (
    .CLOCK_50 (clk),
    .KEY      (key),
    .io       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Digit table copied from the display definition.
  logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                               7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                               7'h46, 7'h21, 7'h06, 7'h0E};

  typedef struct {
    string           name;
    logic [9:0]      ledr;
    logic            chk_hex;
    logic [5:0][6:0] hex;
  } exp_t;

  exp_t sb [$];

  // Reference model: edges since reset release, model of S, done flag.
  int         fill_edges;
  logic       model_done;
  logic [7:0] model_s [256];

  task automatic tick();
    @(posedge clk);
    if (key[3]) begin
      fill_edges = 0;
      model_done = 1'b0;
    end else if (fill_edges < 256) begin
      model_s[fill_edges] = fill_edges[7:0];
      fill_edges++;
      if (fill_edges == 256) model_done = 1'b1;
    end
    #1;
  endtask

  // Push expectation for the current (settled) SW address.
  task automatic expect_now(input string name, input logic chk_hex);
    exp_t       e;
    logic [7:0] v;
    logic [6:0] hi, lo;
    v  = model_s[bus.SW[7:0]];
    hi = model_done ? seg_tbl[v[7:4]] : 7'h7F;
    lo = model_done ? seg_tbl[v[3:0]] : 7'h7F;
    e.name    = name;
    e.ledr    = {9'b0, model_done};
    e.chk_hex = chk_hex;
    e.hex     = {7'h7F, 7'h7F, 7'h7F, 7'h7F, hi, lo};
    sb.push_back(e);
  endtask

  // Let the monitor consume pending expectations at the next falling edge.
  task automatic sample();
    probe = 1'b1;
    @(negedge clk);
    #1;
    probe = 1'b0;
  endtask

  task automatic readback(input logic [7:0] a, input string name);
    bus.SW[7:0] = a;
    tick();
    tick();
    expect_now(name, 1'b1);
    sample();
  endtask

  // Fill edges with the ignored inputs and the address toggling at random.
  task automatic run_fill(input int n);
    for (int k = 0; k < n; k++) begin
      key[2:0] = 3'($urandom);
      bus.SW   = 10'($urandom);
      tick();
      if (k % 37 == 0) begin
        expect_now("fill_blank", 1'b1);
        sample();
      end
    end
  endtask

  // Monitor: compares observed outputs against queued expectations.
  always @(negedge clk) begin
    if (probe) begin
      while (sb.size() > 0) begin
        exp_t e;
        logic [5:0][6:0] obs;
        e   = sb.pop_front();
        obs = {bus.HEX5, bus.HEX4, bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0};
        checks++;
        if (bus.LEDR !== e.ledr || (e.chk_hex && obs !== e.hex)) begin
          errors++;
          $display("FAIL %s: got LEDR=%h HEX5..0=%h, expected LEDR=%h HEX5..0=%h (hex checked=%0d)",
                   e.name, bus.LEDR, obs, e.ledr, e.hex, e.chk_hex);
        end
      end
    end
  end

  initial begin
    checks     = 0;
    errors     = 0;
    probe      = 1'b0;
    fill_edges = 0;
    model_done = 1'b0;
    key        = 4'b1000;
    bus.SW     = '0;

    // Reset held for 3 edges.
    repeat (3) begin
      tick();
      expect_now("reset_hold", 1'b1);
      sample();
    end

    // First fill: done after exactly 256 edges.
    key[3] = 1'b0;
    run_fill(255);
    expect_now("done_at_255", 1'b1);
    sample();
    tick();
    expect_now("done_at_256", 1'b0);
    sample();
    key[2:0]  = 3'b000;
    bus.SW    = '0;

    // Directed readback values.
    readback(8'h00, "rb_00");
    readback(8'hA5, "rb_A5");
    readback(8'hFF, "rb_FF");

    // Full sweep.
    for (int a = 0; a < 256; a++) readback(8'(a), "sweep");

    // Reset while in DONE, then reset again at edge 100 of the new fill.
    key[3] = 1'b1;
    tick();
    expect_now("reset_in_done", 1'b1);
    sample();
    key[3] = 1'b0;
    run_fill(100);
    key[3] = 1'b1;
    tick();
    expect_now("reset_mid_fill", 1'b1);
    sample();
    key[3] = 1'b0;
    run_fill(255);
    expect_now("refill_at_255", 1'b1);
    sample();
    tick();
    expect_now("refill_at_256", 1'b0);
    sample();

    // Random readback after refill, with ignored bits wiggling.
    for (int n = 0; n < 40; n++) begin
      key[2:0]    = 3'($urandom);
      bus.SW[9:8] = 2'($urandom);
      readback(8'($urandom_range(0, 255)), "rb_random");
    end

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
